// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: frame geometry, FSM
// state encoding and the baud divider helper.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sched_state_e;

  // Clock cycles per bit time (truncating division).
  function automatic int baud_clk(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from ptr+1, wrapping modulo N_REQ.
module uart_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;
  logic       found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    // ptr is always a legal index, so ptr+i stays below 2*N_REQ
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART byte transmitter among N_REQ sources, with
// frame timing derived from CLK/BAUD. Optional macro: UART_SCHED_URGENT0_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLK      = 50000000,
  parameter int BAUD     = 115200,
  parameter int N_REQ    = 4,
  parameter int GAP_BITS = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_flag,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int BAUD_CLK  = baud_clk(CLK, BAUD);
  localparam int FRAME_CYC = (FRAME_BITS + GAP_BITS) * BAUD_CLK;
  localparam int CNT_W     = $clog2(FRAME_CYC + 1);
  localparam int IDX_W     = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYC - 2);

  // Handshake: a source holds req_valid[i] and its byte until it sees the
  // one-cycle req_ack[i]; it must drop or advance both in the following cycle.
  // Requests are only sampled in IDLE, never during the ack cycle.

  sched_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              flag_q, flag_d;
  logic [N_REQ-1:0]  ack_q, ack_d;

  logic [N_REQ-1:0]  arb_req;
  logic [N_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic              urgent_win;
  logic [N_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic [7:0]        win_data;

`ifdef UART_SCHED_URGENT0_EN
  // Requester 0 bypasses rotation; the others rotate among themselves.
  assign arb_req    = {req_valid[N_REQ-1:1], 1'b0};
  assign urgent_win = req_valid[0];
`else
  assign arb_req    = req_valid;
  assign urgent_win = 1'b0;
`endif

  uart_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (arb_req),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign win_onehot = urgent_win ? N_REQ'(1) : arb_grant;
  assign win_idx    = urgent_win ? '0 : arb_idx;
  assign win_any    = urgent_win | arb_any;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_data = win_data | (req_data[8*i +: 8] & {8{win_onehot[i]}});
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    flag_d     = 1'b0;
    ack_d      = '0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (win_any) begin
          state_d    = SEND;
          busy_d     = 1'b1;
          tx_data_d  = win_data;
          grant_id_d = win_idx;
          if (!urgent_win) ptr_d = win_idx;
          flag_d     = 1'b1;
          ack_d      = win_onehot;
        end
      end
      SEND: begin
        // Leaving two cycles early puts the IDLE grant cycle and the flag
        // register delay inside the FRAME_CYC spacing.
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      grant_id_q <= '0;
      ptr_q      <= IDX_W'(N_REQ - 1);
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      flag_q     <= flag_d;
      ack_q      <= ack_d;
    end
  end

  assign req_ack  = ack_q;
  assign tx_data  = tx_data_q;
  assign tx_flag  = flag_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table of request bursts plus
// hand-written sequences for late requests, serial framing and reset.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD_R = 10_000;
  localparam int N      = 4;
  localparam int GAP    = 1;
  localparam int BCLK   = 100;                 // 1e6 / 1e4
  localparam int FRAME  = (10 + GAP) * BCLK;   // 1100
  localparam int W      = 10;                  // {grant_id, tx_data}

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [7:0]     tx_data;
  logic           tx_flag;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_scheduler #(
    .CLK      (CLK_HZ),
    .BAUD     (BAUD_R),
    .N_REQ    (N),
    .GAP_BITS (GAP)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish earlier", cyc);
    $fatal(1);
  end

  // ---------------- transmitter and line decoder models ----------------
  logic [9:0] txm_sh = 10'h3FF;
  int         txm_bits = 0;
  int         txm_tmr = 0;
  logic       line;
  assign line = (txm_bits > 0) ? txm_sh[0] : 1'b1;

  always @(posedge clk) begin
    if (tx_flag) begin
      txm_sh   <= {STOP_BIT, tx_data, START_BIT};
      txm_bits <= FRAME_BITS;
      txm_tmr  <= 0;
    end else if (txm_bits > 0) begin
      if (txm_tmr == BCLK - 1) begin
        txm_tmr  <= 0;
        txm_sh   <= {1'b1, txm_sh[9:1]};
        txm_bits <= txm_bits - 1;
      end else begin
        txm_tmr <= txm_tmr + 1;
      end
    end
  end

  logic [7:0] rx_byte [64];
  logic       rx_ok [64];
  int         rx_start [64];
  int         rx_n = 0;
  int         rx_busy = 0;
  int         rx_tmr = 0;
  int         rx_bit = 0;
  logic [9:0] rx_sh = '0;

  always @(posedge clk) begin
    if (rx_busy == 0) begin
      if (line == 1'b0) begin
        rx_busy <= 1;
        rx_tmr  <= 1;
        rx_bit  <= 0;
        rx_start[rx_n & 63] <= cyc;
      end
    end else begin
      rx_tmr <= rx_tmr + 1;
      if (rx_tmr == BCLK / 2 + rx_bit * BCLK) begin
        rx_sh  <= {line, rx_sh[9:1]};
        rx_bit <= rx_bit + 1;
        if (rx_bit == 9) begin
          rx_byte[rx_n & 63] <= rx_sh[9:2];
          rx_ok[rx_n & 63]   <= (rx_sh[1] == START_BIT) && (line == STOP_BIT);
          rx_n    <= rx_n + 1;
          rx_busy <= 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [W-1:0] exp_q[$];
  int         cnt [N];
  logic [7:0] dat [N];
  int         last_flag_cyc = -1;
  int         flags_seen = 0;
  int         busy_cycles = 0;
  logic [7:0] last_tx_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (cnt[i] > 0);
      req_data[8*i +: 8] = dat[i];
    end
  endtask

  task automatic step();
    logic [W-1:0] e;
    @(negedge clk);
    if (busy) busy_cycles++;
    if (tx_flag) begin
      flags_seen++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_flag");
      end else begin
        e = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e[9:8]));
        chk("tx_data", 32'(tx_data), 32'(e[7:0]));
      end
      chk("ack_onehot", 32'(req_ack), 32'(4'b0001 << grant_id));
      if (last_flag_cyc >= 0) chk("flag_spacing", 32'(cyc - last_flag_cyc), 32'(FRAME));
      last_flag_cyc = cyc;
      last_tx_data  = tx_data;
    end else begin
      chk("ack_without_flag", 32'(req_ack), 32'h0);
      chk("tx_data_hold", 32'(tx_data), 32'(last_tx_data));
    end
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        cnt[i]--;
        dat[i]++;
      end
    end
    apply_reqs();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3 * FRAME && busy; k++) step();
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic start_burst();
    wait_idle();
    last_flag_cyc = -1;
    flags_seen    = 0;
    busy_cycles   = 0;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += cnt[i];
    return s;
  endfunction

  task automatic drain(input int n);
    int k;
    step();
    chk("grant_latency", 32'(tx_flag), 32'h1);
    k = 0;
    while ((busy || pending() > 0) && k < (n + 1) * FRAME) begin
      step();
      k++;
    end
    if (busy) fail_now("drain_timeout");
    chk("flag_count", 32'(flags_seen), 32'(n));
    chk("busy_cycles", 32'(busy_cycles), 32'(n * FRAME));
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      dat[i] = 8'h00;
    end
    exp_q.delete();
    last_tx_data  = 8'h00;
    last_flag_cyc = -1;
    apply_reqs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_flag"}, 32'(tx_flag), 32'h0);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'h0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] mask;   // requesters with one byte each
    logic [7:0] base;   // requester i offers base+i
    int         n;      // number of grants
    logic [7:0] ord;    // expected grant order, 2 bits each, first in [1:0]
  } vec_t;

  vec_t vecs [7];

  initial begin
    int rx0;
    vecs[0] = '{4'b0100, 8'hA3, 1, 8'b00_00_00_10};  // lone requester 2, byte A5
    vecs[1] = '{4'b1111, 8'h10, 4, 8'b10_01_00_11};  // ptr=2: 3,0,1,2
    vecs[2] = '{4'b0011, 8'h40, 2, 8'b00_00_01_00};  // ptr=2: 0,1
    vecs[3] = '{4'b1001, 8'h70, 2, 8'b00_00_00_11};  // ptr=1: 3,0
    vecs[4] = '{4'b0110, 8'hC0, 2, 8'b00_00_10_01};  // ptr=0: 1,2
    vecs[5] = '{4'b1000, 8'hE0, 1, 8'b00_00_00_11};  // ptr=2: 3
    vecs[6] = '{4'b0001, 8'h05, 1, 8'b00_00_00_00};  // ptr=3 wraps to 0

    rstn = 1'b1;
    req_valid = '0;
    req_data  = '0;
    #1 rstn = 1'b0;
    reset_dut();
    @(negedge clk);
    chk_reset_outputs("reset");

    for (int v = 0; v < 7; v++) begin
      logic [1:0] g;
      start_burst();
      for (int i = 0; i < N; i++) begin
        cnt[i] = vecs[v].mask[i] ? 1 : 0;
        dat[i] = vecs[v].base + 8'(i);
      end
      for (int k = 0; k < vecs[v].n; k++) begin
        g = vecs[v].ord[2*k +: 2];
        exp_q.push_back({g, vecs[v].base + 8'(g)});
      end
      apply_reqs();
      drain(vecs[v].n);
    end

    // All four continuously valid after reset; requester 0 has two bytes.
    reset_dut();
    start_burst();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 1;
      dat[i] = 8'h20 + 8'(i);
    end
    cnt[0] = 2;
    exp_q.push_back({2'd0, 8'h20});
    exp_q.push_back({2'd1, 8'h21});
    exp_q.push_back({2'd2, 8'h22});
    exp_q.push_back({2'd3, 8'h23});
    exp_q.push_back({2'd0, 8'h21});
    apply_reqs();
    drain(5);

    // Request rising mid-frame must wait for the frame to end.
    begin
      int first_flag;
      int k;
      start_burst();
      cnt[2] = 1;
      dat[2] = 8'h99;
      exp_q.push_back({2'd2, 8'h99});
      apply_reqs();
      step();
      chk("late_first_flag", 32'(tx_flag), 32'h1);
      first_flag = cyc;
      repeat (100) step();
      cnt[1] = 1;
      dat[1] = 8'h66;
      exp_q.push_back({2'd1, 8'h66});
      apply_reqs();
      k = 0;
      while (!tx_flag && k < 2 * FRAME) begin
        step();
        k++;
      end
      if (!tx_flag) fail_now("late_ack_timeout");
      else chk("late_ack_time", 32'(cyc - first_flag), 32'(FRAME));
      wait_idle();
    end

    // Serial framing of 55 then 0F through the transmitter model.
    reset_dut();
    rx0 = rx_n;
    start_burst();
    cnt[0] = 1;
    dat[0] = 8'h55;
    cnt[1] = 1;
    dat[1] = 8'h0F;
    exp_q.push_back({2'd0, 8'h55});
    exp_q.push_back({2'd1, 8'h0F});
    apply_reqs();
    drain(2);
    for (int k = 0; k < 2 * FRAME && rx_n < rx0 + 2; k++) step();
    if (rx_n < rx0 + 2) begin
      fail_now("rx_timeout");
    end else begin
      chk("rx_byte0", 32'(rx_byte[rx0 & 63]), 32'h55);
      chk("rx_byte1", 32'(rx_byte[(rx0 + 1) & 63]), 32'h0F);
      chk("rx_frame0_ok", 32'(rx_ok[rx0 & 63]), 32'h1);
      chk("rx_frame1_ok", 32'(rx_ok[(rx0 + 1) & 63]), 32'h1);
      chk("rx_idle_gap", 32'((rx_start[(rx0 + 1) & 63] - rx_start[rx0 & 63] - 10 * BCLK) >= GAP * BCLK), 32'h1);
    end

    // Reset mid-frame, then requesters 0 and 1 valid across the release.
    start_burst();
    cnt[2] = 1;
    dat[2] = 8'hC3;
    exp_q.push_back({2'd2, 8'hC3});
    apply_reqs();
    step();
    repeat (499) step();
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midframe_reset");
    last_tx_data  = 8'h00;
    last_flag_cyc = -1;
    flags_seen    = 0;
    busy_cycles   = 0;
    cnt[0] = 1;
    dat[0] = 8'h31;
    cnt[1] = 1;
    dat[1] = 8'h32;
    exp_q.push_back({2'd0, 8'h31});
    exp_q.push_back({2'd1, 8'h32});
    apply_reqs();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    drain(2);

    // Reset in the ack cycle: ack and flag vanish and the byte is not re-sent.
    start_burst();
    cnt[3] = 1;
    dat[3] = 8'hE7;
    exp_q.push_back({2'd3, 8'hE7});
    apply_reqs();
    step();
    chk("ackcycle_flag_seen", 32'(tx_flag), 32'h1);
    rstn = 1'b0;
    #1;
    chk("ackcycle_reset_flag", 32'(tx_flag), 32'h0);
    chk("ackcycle_reset_ack", 32'(req_ack), 32'h0);
    chk("ackcycle_reset_busy", 32'(busy), 32'h0);
    last_tx_data  = 8'h00;
    last_flag_cyc = -1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    flags_seen = 0;
    repeat (50) step();
    chk("ackcycle_no_resend", 32'(flags_seen), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
